// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO.
// Radix-2: one shift-add (multiply) or restoring shift-subtract (divide) step
// per cycle on operand magnitudes, followed by a two-cycle sign fix/commit.
// Optional MTHI/MTLO write port is enabled by defining MDU_HILO_WRITE_EN.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
`ifdef MDU_HILO_WRITE_EN
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;    // {HI part, LO part} working register
  logic [WIDTH-1:0]   b_q, b_d;        // multiplicand / divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;  // negate product or quotient
  logic               neg_rem_q, neg_rem_d;  // negate remainder
  logic               dz_q, dz_d;
  logic               fix_q, fix_d;    // second FIX cycle commits HI/LO
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand magnitudes for the signed variants (op_i[0] set).
  logic [WIDTH-1:0] abs1, abs2;
  assign abs1 = (op_i[0] && src1_i[WIDTH-1]) ? -src1_i : src1_i;
  assign abs2 = (op_i[0] && src2_i[WIDTH-1]) ? -src2_i : src2_i;

  // Multiply step: conditionally add multiplicand into the upper half.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

  // Divide step: WIDTH+1-bit trial subtract of the shifted partial remainder.
  logic [WIDTH:0]   div_shift, div_trial;
  logic [WIDTH-1:0] div_rem;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, b_q};
  assign div_rem   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];

  // Sign-corrected forms used in FIX.
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   rem_neg, quo_neg;
  assign prod_neg = -acc_q;
  assign rem_neg  = -acc_q[2*WIDTH-1:WIDTH];
  assign quo_neg  = -acc_q[WIDTH-1:0];

  // Next-state and datapath logic for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    fix_d     = fix_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
`ifdef MDU_HILO_WRITE_EN
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
`endif
        if (start_i) begin
          is_div_d  = op_i[1];
          neg_res_d = op_i[0] & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
          neg_rem_d = op_i[0] & src1_i[WIDTH-1];
          dz_d      = op_i[1] && (src2_i == '0);
          b_d       = abs2;
          // A zero divisor keeps the raw dividend: it becomes HI unchanged.
          acc_d     = {{WIDTH{1'b0}}, (dz_d ? src1_i : abs1)};
          cnt_d     = CW'(WIDTH);
          fix_d     = 1'b0;
          state_d   = dz_d ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (is_div_q)
          acc_d = {div_rem, acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
        else
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!fix_q) begin
          // Phase 0: register the sign-corrected result.
          if (dz_q)
            acc_d = {acc_q[WIDTH-1:0], {WIDTH{1'b1}}};
          else if (is_div_q)
            acc_d = {(neg_rem_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH]),
                     (neg_res_q ? quo_neg : acc_q[WIDTH-1:0])};
          else if (neg_res_q)
            acc_d = prod_neg;
          fix_d = 1'b1;
        end else begin
          // Phase 1: commit to HI/LO.
          hi_d    = acc_q[2*WIDTH-1:WIDTH];
          lo_d    = acc_q[WIDTH-1:0];
          fix_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      fix_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      fix_q     <= fix_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o     = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o     = (state_q == S_DONE);
  assign div_zero_o = (state_q == S_DONE) && dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
